// File: rtl/csa_pkg.sv
// Shared types and constants for the sequential carry-select adder controller.
// Holds the FSM encoding plus the slice width and requester count.
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB_W   = 4;
    localparam int NUM_REQ = 2;

endpackage

// File: rtl/csa_slice4.sv
// 4-bit carry-select slice: both carry hypotheses computed, cin picks one.
// Latency: combinational. Backpressure: none (pure datapath).
// Flow: none; the caller sequences nibbles through it.
module csa_slice4
    import csa_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic [NIB_W:0] sum_c0;
    logic [NIB_W:0] sum_c1;

    assign sum_c0 = {1'b0, a} + {1'b0, b};
    assign sum_c1 = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, 1'b1};

    assign {cout, s} = cin ? sum_c1 : sum_c0;

endmodule

// File: rtl/csa_seq_ctrl.sv
// Two-requester round-robin adder sequencing one 4-bit slice over WIDTH/4 nibbles, LSB first.
// Latency: rsp_valid in the WIDTH/4+1-th cycle after the accept cycle; one idle cycle between jobs.
// Backpressure: result held in DONE until rsp_ready; readies only in IDLE. CSA_SEQ_OVF_EN adds rsp_ovf.
module csa_seq_ctrl
    import csa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_id,
`ifdef CSA_SEQ_OVF_EN
    output logic             rsp_ovf,
`endif
    output logic             busy
);

    localparam int NIBS = WIDTH / NIB_W;
    localparam int CW   = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBS - 1);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt;
    logic             carry_q;
    logic             id_q;
    logic             last_q;
    logic             valid_q;
    logic             busy_q;
`ifdef CSA_SEQ_OVF_EN
    logic             ovf_q;
`endif

    logic             gnt_id;
    logic             can_acc;
    logic             accept;
    logic [NIB_W-1:0] a_nib;
    logic [NIB_W-1:0] b_nib;
    logic [NIB_W-1:0] nib_s;
    logic             nib_c;

    // last_q holds the previous winner; reset to 1 so req0 wins the first tie.
    always_comb begin
        gnt_id = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_id = ~last_q;
        end else if (req1_valid) begin
            gnt_id = 1'b1;
        end
    end

    assign can_acc    = (state == IDLE) && !rst;
    assign req0_ready = can_acc && req0_valid && !gnt_id;
    assign req1_ready = can_acc && req1_valid && gnt_id;
    assign accept     = req0_ready || req1_ready;

    assign a_nib = a_q[cnt*NIB_W +: NIB_W];
    assign b_nib = b_q[cnt*NIB_W +: NIB_W];

    csa_slice4 u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .s    (nib_s),
        .cout (nib_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef CSA_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q     <= gnt_id ? req1_a : req0_a;
                        b_q     <= gnt_id ? req1_b : req0_b;
                        carry_q <= gnt_id ? req1_cin : req0_cin;
                        id_q    <= gnt_id;
                        last_q  <= gnt_id;
                        sum_q   <= '0;
                        cnt     <= '0;
                        busy_q  <= 1'b1;
`ifdef CSA_SEQ_OVF_EN
                        ovf_q   <= 1'b0;
`endif
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum_q[cnt*NIB_W +: NIB_W] <= nib_s;
                    carry_q <= nib_c;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        valid_q <= 1'b1;
`ifdef CSA_SEQ_OVF_EN
                        // carry into the MSB recovered from its sum bit
                        ovf_q   <= a_nib[NIB_W-1] ^ b_nib[NIB_W-1] ^ nib_s[NIB_W-1] ^ nib_c;
`endif
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = valid_q;
    assign rsp_sum   = valid_q ? sum_q : '0;
    assign rsp_cout  = valid_q & carry_q;
    assign rsp_id    = valid_q & id_q;
    assign busy      = busy_q;
`ifdef CSA_SEQ_OVF_EN
    assign rsp_ovf   = valid_q & ovf_q;
`endif

endmodule

// File: tb/tb_csa_seq_ctrl.sv
// Directed bench for csa_seq_ctrl at WIDTH=16 with hand-computed sums, latency and grant order.
module tb_csa_seq_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_cin, req1_cin;
    logic         rsp_valid, rsp_ready;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout, rsp_id, busy;
`ifdef CSA_SEQ_OVF_EN
    logic         rsp_ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    csa_seq_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_id     (rsp_id),
`ifdef CSA_SEQ_OVF_EN
        .rsp_ovf    (rsp_ovf),
`endif
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_accept(input int exp_id);
        int id = -1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req0_ready || req1_ready) begin
                id = req1_ready ? 1 : 0;
                chk("single_ready", 32'(req0_ready & req1_ready), 0);
                break;
            end
            @(negedge clk);
        end
        chk("grant_id", id, exp_id);
        @(posedge clk);
    endtask

    // Counts negedges after the accept edge until rsp_valid; releasing also scrambles operands.
    task automatic wait_rsp(input bit release_req, output int lat);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                chk("busy_run", 32'(busy), 1);
                chk("sum_zero_run", 32'(rsp_sum), 0);
                if (release_req) begin
                    req0_valid = 1'b0;
                    req1_valid = 1'b0;
                    req0_a = 16'($urandom);
                    req0_b = 16'($urandom);
                    req1_a = 16'($urandom);
                    req1_b = 16'($urandom);
                end else begin
                    chk("no_ready_run", 32'(req0_ready | req1_ready), 0);
                end
            end
            if (rsp_valid) break;
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("busy_after_hs", 32'(busy), 0);
        chk("valid_after_hs", 32'(rsp_valid), 0);
        chk("sum_after_hs", 32'(rsp_sum), 0);
        chk("id_after_hs", 32'(rsp_id), 0);
    endtask

    task automatic run_job(input int exp_id, input logic [W-1:0] exp_sum, input logic exp_cout,
                           input logic exp_ovf, input bit release_req, input int stall);
        int lat;
        wait_accept(exp_id);
        wait_rsp(release_req, lat);
        chk("latency", lat, 5);
        chk("sum", 32'(rsp_sum), 32'(exp_sum));
        chk("cout", 32'(rsp_cout), 32'(exp_cout));
        chk("id", 32'(rsp_id), exp_id);
`ifdef CSA_SEQ_OVF_EN
        chk("ovf", 32'(rsp_ovf), 32'(exp_ovf));
`endif
        if (stall > 0) begin
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            for (int i = 0; i < stall; i++) begin
                #1;
                chk("stall_valid", 32'(rsp_valid), 1);
                chk("stall_sum", 32'(rsp_sum), 32'(exp_sum));
                chk("stall_cout", 32'(rsp_cout), 32'(exp_cout));
                chk("stall_id", 32'(rsp_id), exp_id);
                chk("stall_ready", 32'(req0_ready | req1_ready), 0);
                @(negedge clk);
            end
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        finish_rsp();
    endtask

    task automatic set_req(input int sel, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        if (sel == 0) begin
            req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int pulses;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        do_reset();

        chk("rst_req0_ready", 32'(req0_ready), 0);
        chk("rst_req1_ready", 32'(req1_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_sum", 32'(rsp_sum), 0);
        chk("rst_rsp_cout", 32'(rsp_cout), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_busy", 32'(busy), 0);

        // full-width carry ripple; operands scrambled after accept
        set_req(0, 16'hFFFF, 16'h0001, 1'b0);
        run_job(0, 16'h0000, 1'b1, 1'b0, 1'b1, 0);

        // simultaneous requests from reset, held valid: grants 0,1,0
        do_reset();
        set_req(0, 16'h0001, 16'h0002, 1'b0);
        set_req(1, 16'h00F0, 16'h0F10, 1'b1);
        run_job(0, 16'h0003, 1'b0, 1'b0, 1'b0, 0);
        run_job(1, 16'h1001, 1'b0, 1'b0, 1'b0, 0);
        run_job(0, 16'h0003, 1'b0, 1'b0, 1'b0, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);

        // consumer stalls 10 cycles in DONE; signed overflow case
        set_req(0, 16'h7FFF, 16'h0001, 1'b0);
        run_job(0, 16'h8000, 1'b0, 1'b1, 1'b1, 10);

        // reset in the 2nd RUN cycle aborts the job
        set_req(0, 16'hAAAA, 16'h5555, 1'b1);
        wait_accept(0);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (rsp_valid) pulses++;
            @(negedge clk);
        end
        chk("abort_no_valid", pulses, 0);

        set_req(1, 16'h1234, 16'h4321, 1'b1);
        run_job(1, 16'h5556, 1'b0, 1'b0, 1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
